output_pipeline: RTL and testbench
==================================

OUTPUT_PIPELINE -- requirements
Module: output_pipeline

Interface
REQ-001 SHALL have parameter ADDRESS_OF_LAST, default 15'd19199, giving the index of the last 128-bit image word per half.
REQ-002 SHALL have `clock`, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-003 SHALL have `rst_n`, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have `start`, input, 1 bit: level enable, held high for the whole run.
REQ-005 SHALL have `inputBaseOffset`, input, 1 bit: image half select, used as address bit 15.
REQ-006 SHALL have `m3ReadBus`, input, 128 bits: original-image word of 16 pixels; pixel k is bits [8k+7:8k].
REQ-007 SHALL have `m2ReadBus`, input, 128 bits: equalization table word; [7:0] is the mapped pixel and [35:20] is the tag.
REQ-008 SHALL have `m3ReadAddr`, output, 16 bits: image word address.
REQ-009 SHALL have `m2ReadAddr`, output, 16 bits: table address, equal to {8'h00, pixel}.
REQ-010 SHALL have `m4WriteAddr`, output, 16 bits: output word address.
REQ-011 SHALL have `m4WriteBus`, output, 128 bits: equalized word.
REQ-012 SHALL have `m4WE`, output, 1 bit: output write strobe.
REQ-013 SHALL have `done`, output, 1 bit: run complete.
REQ-014 SHALL have `tagError`, output, 1 bit: sticky table-tag error.

Function
REQ-015 SHALL treat m2 and m3 as synchronous-read memories: data is valid on the read bus in the cycle after the address is presented.
REQ-016 SHALL implement states IDLE, FETCH, LOAD, LOOKUP, LAST, WRITE, DONE.
REQ-017 SHALL go IDLE->FETCH when start=1; FETCH SHALL drive m3ReadAddr={inputBaseOffset, wordCnt}.
REQ-018 SHALL, in LOAD, capture m3ReadBus into the 128-bit pixel register and clear laneCnt to 0.
REQ-019 SHALL, in LOOKUP, drive m2ReadAddr={8'h00, pixel[laneCnt]} each cycle and increment laneCnt.
REQ-020 SHALL, in LOOKUP, capture m2ReadBus[7:0] into lane laneCnt-1 of the assembly register.
REQ-021 SHALL issue lanes 0..15 in consecutive cycles and move LOOKUP->LAST after lane 15 is issued.
REQ-022 SHALL, in LAST, capture the lane 15 result.
REQ-023 SHALL, in WRITE, assert m4WE=1 for exactly one cycle, with m4WriteBus=assembly register and m4WriteAddr={inputBaseOffset, wordCnt}.
REQ-024 SHALL, after WRITE, go to DONE if wordCnt==ADDRESS_OF_LAST; otherwise it SHALL increment wordCnt and go to FETCH.
REQ-025 SHALL take 20 cycles per word: 1 FETCH, 1 LOAD, 16 LOOKUP, 1 LAST, 1 WRITE.
REQ-026 SHALL write the first word with m4WE high in cycle 20 after start rises (IDLE=cycle 0).
REQ-027 SHALL, in DONE, hold done=1 and m4WE=0 while start=1.
REQ-028 SHALL, whenever start=0 in any non-IDLE state, go to IDLE on the next edge, clear wordCnt, laneCnt and done, force m4WE=0, and discard the partial word without writing it.
REQ-029 SHALL hold m4WE=0 in every state other than WRITE.
REQ-030 SHALL hold wordCnt at 15 bits, never wrap it past ADDRESS_OF_LAST, and write no further addresses once DONE is reached.
REQ-031 SHALL leave m2ReadAddr and m3ReadAddr at 0 when not actively reading.

Reset
REQ-032 SHALL, on rst_n=0, asynchronously force state=IDLE, wordCnt=0, laneCnt=0, pixel and assembly registers=0, and all outputs=0 (m3ReadAddr, m2ReadAddr, m4WriteAddr, m4WriteBus, m4WE, done, tagError).
REQ-033 SHALL, after reset release with start=1, begin at FETCH on the first clock edge.

Configuration
REQ-034 SHALL, with OUTPUT_PIPE_TAG_CHECK_EN defined, substitute 8'h00 for any lane whose m2ReadBus[35:20]!=16'hAAAA.
REQ-035 SHALL, with OUTPUT_PIPE_TAG_CHECK_EN defined, set tagError and keep it set until reset or start=0.
REQ-036 SHALL, without OUTPUT_PIPE_TAG_CHECK_EN, use m2ReadBus[7:0] unconditionally and tie tagError to 0.

Verification
REQ-037 Bench SHALL cover: ADDRESS_OF_LAST=1, identity table (table[v]=v, tag AAAA), m3 word0=16'h00..0F pixels -> m4 word0 equals the input word, m4WE pulses at cycles 20 and 40, done=1 from cycle 41.
REQ-038 Bench SHALL cover: table[v]=255-v, all pixels 8'h10 -> every lane 8'hEF, m4WriteAddr=16'h0000 on the first write.
REQ-039 Bench SHALL cover: inputBaseOffset=1 -> m3ReadAddr and m4WriteAddr equal 16'h8000 for word 0 and 16'h8001 for word 1.
REQ-040 Bench SHALL cover: start dropped in LOOKUP lane 7 -> no m4WE, IDLE next cycle, and restart reads word 0 again.
REQ-041 Bench SHALL cover: rst_n asserted during WRITE -> m4WE=0 immediately and all outputs 0.
REQ-042 Bench SHALL cover, with the macro defined: table entry 8'h05 carries tag 16'h1234 -> pixels of value 5 map to 8'h00 and tagError=1; without the macro, they map to the table value and tagError=0.

Source files
------------

// File: rtl/output_pipeline.sv
`default_nettype none
// ============================================================================
// Module   : output_pipeline
// Purpose  : Equalizes 16-pixel image words through a lookup table, one lane
//            per cycle. Optional tag checking is enabled by defining
//            OUTPUT_PIPE_TAG_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module output_pipeline #(
    parameter logic [14:0] ADDRESS_OF_LAST = 15'd19199
) (
    input  logic         clock,
    input  logic         rst_n,
    input  logic         start,
    input  logic         inputBaseOffset,
    input  logic [127:0] m3ReadBus,
    input  logic [127:0] m2ReadBus,
    output logic [15:0]  m3ReadAddr,
    output logic [15:0]  m2ReadAddr,
    output logic [15:0]  m4WriteAddr,
    output logic [127:0] m4WriteBus,
    output logic         m4WE,
    output logic         done,
    output logic         tagError
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        LOAD   = 3'd2,
        LOOKUP = 3'd3,
        LAST   = 3'd4,
        WRITE  = 3'd5,
        DONE   = 3'd6
    } state_t;

    state_t         state_q,    state_d;
    logic [14:0]    wordCnt_q,  wordCnt_d;
    logic [3:0]     laneCnt_q,  laneCnt_d;
    logic [127:0]   pixel_q,    pixel_d;
    logic [127:0]   asm_q,      asm_d;
    logic           tagErr_q,   tagErr_d;

    logic           w_tagBad;
    logic [7:0]     w_laneVal;
    logic [6:0]     w_rdBit;
    logic [6:0]     w_wrBit;
    logic [3:0]     w_prevLane;
    logic           w_unused;

`ifdef OUTPUT_PIPE_TAG_CHECK_EN
    assign w_tagBad = (m2ReadBus[35:20] != 16'hAAAA);
`else
    assign w_tagBad = 1'b0;
`endif

    assign w_laneVal  = w_tagBad ? 8'h00 : m2ReadBus[7:0];
    assign w_prevLane = laneCnt_q - 4'd1;
    assign w_rdBit    = {laneCnt_q, 3'b000};
    assign w_wrBit    = {w_prevLane, 3'b000};
    assign w_unused   = ^m2ReadBus[127:8];
    assign tagError   = tagErr_q;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            wordCnt_q <= 15'd0;
            laneCnt_q <= 4'd0;
            pixel_q   <= 128'd0;
            asm_q     <= 128'd0;
            tagErr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            wordCnt_q <= wordCnt_d;
            laneCnt_q <= laneCnt_d;
            pixel_q   <= pixel_d;
            asm_q     <= asm_d;
            tagErr_q  <= tagErr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wordCnt_d   = wordCnt_q;
        laneCnt_d   = laneCnt_q;
        pixel_d     = pixel_q;
        asm_d       = asm_q;
        tagErr_d    = tagErr_q;
        m3ReadAddr  = 16'h0000;
        m2ReadAddr  = 16'h0000;
        m4WriteAddr = 16'h0000;
        m4WriteBus  = 128'd0;
        m4WE        = 1'b0;
        done        = 1'b0;

        // Dropping start abandons any partial word and rearms from word 0.
        if (!start) begin
            state_d   = IDLE;
            wordCnt_d = 15'd0;
            laneCnt_d = 4'd0;
            tagErr_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = FETCH;
                end
                FETCH: begin
                    m3ReadAddr = {inputBaseOffset, wordCnt_q};
                    state_d    = LOAD;
                end
                LOAD: begin
                    pixel_d   = m3ReadBus;
                    laneCnt_d = 4'd0;
                    state_d   = LOOKUP;
                end
                LOOKUP: begin
                    // Table data lags its address by one cycle, so lane N-1 lands now.
                    m2ReadAddr = {8'h00, pixel_q[w_rdBit +: 8]};
                    laneCnt_d  = laneCnt_q + 4'd1;
                    if (laneCnt_q != 4'd0) begin
                        asm_d[w_wrBit +: 8] = w_laneVal;
                        tagErr_d            = tagErr_q | w_tagBad;
                    end
                    if (laneCnt_q == 4'd15) begin
                        state_d = LAST;
                    end
                end
                LAST: begin
                    asm_d[127:120] = w_laneVal;
                    tagErr_d       = tagErr_q | w_tagBad;
                    state_d        = WRITE;
                end
                WRITE: begin
                    m4WE        = 1'b1;
                    m4WriteBus  = asm_q;
                    m4WriteAddr = {inputBaseOffset, wordCnt_q};
                    if (wordCnt_q == ADDRESS_OF_LAST) begin
                        state_d = DONE;
                    end else begin
                        wordCnt_d = wordCnt_q + 15'd1;
                        state_d   = FETCH;
                    end
                end
                DONE: begin
                    done = 1'b1;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_output_pipeline.sv
`default_nettype none
// ============================================================================
// Module   : tb_output_pipeline
// Purpose  : Directed self-checking bench for output_pipeline (2-word image).
// Revision : 1.0 - initial release
// ============================================================================
module tb_output_pipeline;

    logic         clock = 1'b0;
    logic         rst_n;
    logic         start;
    logic         inputBaseOffset;
    logic [127:0] m3ReadBus;
    logic [127:0] m2ReadBus;
    logic [15:0]  m3ReadAddr;
    logic [15:0]  m2ReadAddr;
    logic [15:0]  m4WriteAddr;
    logic [127:0] m4WriteBus;
    logic         m4WE;
    logic         done;
    logic         tagError;

    output_pipeline #(.ADDRESS_OF_LAST(15'd1)) dut (
        .clock           (clock),
        .rst_n           (rst_n),
        .start           (start),
        .inputBaseOffset (inputBaseOffset),
        .m3ReadBus       (m3ReadBus),
        .m2ReadBus       (m2ReadBus),
        .m3ReadAddr      (m3ReadAddr),
        .m2ReadAddr      (m2ReadAddr),
        .m4WriteAddr     (m4WriteAddr),
        .m4WriteBus      (m4WriteBus),
        .m4WE            (m4WE),
        .done            (done),
        .tagError        (tagError)
    );

    always #5 clock = ~clock;

    // Synchronous-read memory models: index by half-select and word LSB.
    logic [127:0] m3mem [4];
    logic [127:0] tbl   [256];

    always @(posedge clock) begin
        m3ReadBus <= m3mem[{m3ReadAddr[15], m3ReadAddr[0]}];
        m2ReadBus <= tbl[m2ReadAddr[7:0]];
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] entry(input logic [7:0] v, input logic [15:0] tag);
        return {92'd0, tag, 12'd0, v};
    endfunction

    function automatic logic [127:0] fill(input logic [7:0] base, input logic [7:0] step);
        logic [127:0] w;
        for (int k = 0; k < 16; k++) w[8*k +: 8] = base + step * 8'(k);
        return w;
    endfunction

    int           we_n;
    int           we_cyc  [2];
    logic [127:0] we_bus  [2];
    logic [15:0]  we_addr [2];
    logic [15:0]  a1, a21, m2_atdrop, m2_afterdrop;
    logic         d40, d41, te_end;

    // Raises start at the current falling edge (cycle 0) and samples every
    // falling edge up to ncyc; start is dropped right after sampling drop_at.
    task automatic run(input int ncyc, input int drop_at);
        we_n = 0;
        start = 1'b1;
        for (int c = 0; c <= ncyc; c++) begin
            if (c > 0) @(negedge clock);
            if (m4WE) begin
                if (we_n < 2) begin
                    we_cyc[we_n]  = c;
                    we_bus[we_n]  = m4WriteBus;
                    we_addr[we_n] = m4WriteAddr;
                end
                we_n++;
            end
            if (c == 1)  a1  = m3ReadAddr;
            if (c == 21) a21 = m3ReadAddr;
            if (c == 40) d40 = done;
            if (c == 41) d41 = done;
            if (c == drop_at)     m2_atdrop    = m2ReadAddr;
            if (c == drop_at + 1) m2_afterdrop = m2ReadAddr;
            te_end = tagError;
            if (c == drop_at) start = 1'b0;
        end
    endtask

    task automatic stop();
        start = 1'b0;
        @(negedge clock);
    endtask

    logic [127:0] exp_w;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        inputBaseOffset = 1'b0;
        for (int i = 0; i < 4; i++) m3mem[i] = 128'd0;
        for (int v = 0; v < 256; v++) tbl[v] = entry(8'(v), 16'hAAAA);
        #1;
        check("rst_m3addr", {112'd0, m3ReadAddr}, 128'd0);
        check("rst_m2addr", {112'd0, m2ReadAddr}, 128'd0);
        check("rst_m4addr", {112'd0, m4WriteAddr}, 128'd0);
        check("rst_m4bus",  m4WriteBus, 128'd0);
        check("rst_m4we",   {127'd0, m4WE}, 128'd0);
        check("rst_done",   {127'd0, done}, 128'd0);
        check("rst_tagerr", {127'd0, tagError}, 128'd0);
        @(negedge clock);
        rst_n = 1'b1;
        @(negedge clock);

        // Identity table, two words
        m3mem[0] = 128'h0F0E0D0C0B0A09080706050403020100;
        m3mem[1] = fill(8'hA0, 8'h01);
        run(45, -1);
        check("id_we_count", 128'(we_n), 128'd2);
        check("id_we_cyc0",  128'(we_cyc[0]), 128'd20);
        check("id_we_cyc1",  128'(we_cyc[1]), 128'd40);
        check("id_bus0",     we_bus[0], 128'h0F0E0D0C0B0A09080706050403020100);
        check("id_bus1",     we_bus[1], fill(8'hA0, 8'h01));
        check("id_addr1",    {112'd0, we_addr[1]}, 128'h1);
        check("id_done40",   {127'd0, d40}, 128'd0);
        check("id_done41",   {127'd0, d41}, 128'd1);
        stop();
        check("id_done_clr", {127'd0, done}, 128'd0);

        // Inverting table, all pixels 0x10
        for (int v = 0; v < 256; v++) tbl[v] = entry(8'(255 - v), 16'hAAAA);
        m3mem[0] = fill(8'h10, 8'h00);
        run(22, -1);
        check("inv_bus0",  we_bus[0], fill(8'hEF, 8'h00));
        check("inv_addr0", {112'd0, we_addr[0]}, 128'h0000);
        stop();

        // Upper image half
        for (int v = 0; v < 256; v++) tbl[v] = entry(8'(v), 16'hAAAA);
        inputBaseOffset = 1'b1;
        m3mem[2] = fill(8'h20, 8'h02);
        m3mem[3] = fill(8'h33, 8'h00);
        run(45, -1);
        check("hi_m3addr0", {112'd0, a1},  128'h8000);
        check("hi_m3addr1", {112'd0, a21}, 128'h8001);
        check("hi_m4addr0", {112'd0, we_addr[0]}, 128'h8000);
        check("hi_m4addr1", {112'd0, we_addr[1]}, 128'h8001);
        check("hi_bus0",    we_bus[0], fill(8'h20, 8'h02));
        stop();

        // Drop start during lane 7 of word 1, then restart
        run(40, 30);
        check("drop_we_count", 128'(we_n), 128'd1);
        check("drop_lane7",    {112'd0, m2_atdrop}, 128'h0033);
        check("drop_idle",     {112'd0, m2_afterdrop}, 128'h0000);
        run(22, -1);
        check("restart_m3addr", {112'd0, a1}, 128'h8000);
        check("restart_cyc",    128'(we_cyc[0]), 128'd20);
        check("restart_bus",    we_bus[0], fill(8'h20, 8'h02));
        stop();

        // Asynchronous reset in WRITE
        start = 1'b1;
        repeat (20) @(negedge clock);
        check("rw_we_before", {127'd0, m4WE}, 128'd1);
        rst_n = 1'b0;
        #1;
        check("rw_we",     {127'd0, m4WE}, 128'd0);
        check("rw_bus",    m4WriteBus, 128'd0);
        check("rw_m4addr", {112'd0, m4WriteAddr}, 128'd0);
        check("rw_m3addr", {112'd0, m3ReadAddr}, 128'd0);
        check("rw_m2addr", {112'd0, m2ReadAddr}, 128'd0);
        check("rw_done",   {127'd0, done}, 128'd0);
        start = 1'b0;
        @(negedge clock);
        rst_n = 1'b1;
        @(negedge clock);

        // Bad tag on table entry 5
        inputBaseOffset = 1'b0;
        tbl[5] = entry(8'h05, 16'h1234);
        m3mem[0] = {{15{8'h05}}, 8'h03};
        run(22, -1);
`ifdef OUTPUT_PIPE_TAG_CHECK_EN
        exp_w = {{15{8'h00}}, 8'h03};
        check("tag_err", {127'd0, te_end}, 128'd1);
`else
        exp_w = {{15{8'h05}}, 8'h03};
        check("tag_err", {127'd0, te_end}, 128'd0);
`endif
        check("tag_bus", we_bus[0], exp_w);
        stop();
        check("tag_err_clr", {127'd0, tagError}, 128'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
